framebuf_writer: RTL and testbench

//  Write-side master of the MIG user port into the 256x192 8bpp framebuffer that vga_display scans.

---
 rtl/framebuf_writer_pkg.sv | 33 +++
 rtl/fb_word_merge.sv | 53 +++++
 rtl/framebuf_writer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_framebuf_writer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/framebuf_writer_pkg.sv
// Shared constants, state encoding and addressing helpers for the framebuffer write master.
// The CLR_* states exist only when FB_CLEAR_EN is defined.
package framebuf_writer_pkg;

    localparam int FB_WIDTH  = 256;
    localparam int FB_HEIGHT = 192;
    localparam int FB_BYTES  = 49152;

    localparam logic [2:0] MIG_INSTR_WRITE = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCUM   = 3'd1,
        S_WR_DATA = 3'd2,
        S_WR_CMD  = 3'd3
`ifdef FB_CLEAR_EN
        ,
        S_CLR_DATA = 3'd4,
        S_CLR_CMD  = 3'd5
`endif
    } state_e;

    // Byte offset of a pixel from the frame base (row-major, one byte per pixel).
    function automatic logic [15:0] fb_offset(input logic [7:0] x, input logic [7:0] y);
        return (16'(y) * 16'(FB_WIDTH)) + 16'(x);
    endfunction

    // Write mask for a single byte lane: 0 marks the byte that gets written.
    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return ~(4'b0001 << lane);
    endfunction

endpackage

// File: rtl/fb_word_merge.sv
// Pixel accumulator: holds one 32-bit word under construction with its byte mask and word address.
// Mask 4'hF means empty; mask 4'h0 means all four bytes are present.
module fb_word_merge (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        merge_i,
    input  logic        clear_i,
    input  logic [27:0] px_word_i,
    input  logic [1:0]  px_lane_i,
    input  logic [7:0]  px_rgb_i,
    output logic [31:0] acc_data_o,
    output logic [3:0]  acc_mask_o,
    output logic [27:0] acc_word_o,
    output logic        empty_o,
    output logic        full_o,
    output logic        same_word_o
);
    import framebuf_writer_pkg::*;

    logic [31:0] data_q;
    logic [3:0]  mask_q;
    logic [27:0] word_q;

    // Accumulator register: load starts a new word, merge overwrites one lane (later write wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 32'h0000_0000;
            mask_q <= 4'hF;
            word_q <= 28'h0;
        end else if (clear_i) begin
            data_q <= 32'h0000_0000;
            mask_q <= 4'hF;
        end else if (load_i) begin
            data_q <= 32'(px_rgb_i) << {px_lane_i, 3'b000};
            mask_q <= lane_mask(px_lane_i);
            word_q <= px_word_i;
        end else if (merge_i) begin
            data_q[{px_lane_i, 3'b000} +: 8] <= px_rgb_i;
            mask_q[px_lane_i]               <= 1'b0;
        end else begin
            data_q <= data_q;
        end
    end

    assign acc_data_o  = data_q;
    assign acc_mask_o  = mask_q;
    assign acc_word_o  = word_q;
    assign empty_o     = (mask_q == 4'hF);
    assign full_o      = (mask_q == 4'h0);
    assign same_word_o = (word_q == px_word_i);

endmodule

// File: rtl/framebuf_writer.sv
// MIG write-side master for the 256x192 8bpp framebuffer: merges same-word pixels into masked writes.
// Define FB_CLEAR_EN to build the hardware full-screen clear (clr_start/clr_rgb).
module framebuf_writer #(
    parameter logic [29:0] FB_BASE_ADDR  = 30'h0,
    parameter int          FLUSH_TIMEOUT = 15,
    parameter int          CLR_BURST     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        px_valid,
    output logic        px_ready,
    input  logic [7:0]  px_x,
    input  logic [7:0]  px_y,
    input  logic [7:0]  px_rgb,
    input  logic        flush,
    input  logic        clr_start,
    input  logic [7:0]  clr_rgb,
    output logic        busy,
    output logic        px_dropped,
    output logic        err,
    output logic        mem_cmd_en,
    output logic [2:0]  mem_cmd_instr,
    output logic [5:0]  mem_cmd_bl,
    output logic [29:0] mem_cmd_byte_addr,
    input  logic        mem_cmd_full,
    input  logic        mem_cmd_empty,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_mask,
    input  logic        mem_wr_full,
    input  logic        mem_wr_empty,
    input  logic [6:0]  mem_wr_count,
    input  logic        mem_wr_underrun,
    input  logic        mem_wr_error
);
    import framebuf_writer_pkg::*;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] out_data_q, out_data_d;
    logic [3:0]  out_mask_q, out_mask_d;
    logic [27:0] out_word_q, out_word_d;
    logic        px_ready_q, busy_q, px_dropped_q, err_q;
    logic        clr_pend_q, clr_pend_d;

    logic        accept_s, in_range_s, drop_s, wr_en_s, cmd_en_s;
    logic        acc_load_s, acc_merge_s, acc_clear_s;
    logic [29:0] px_byte_s;
    logic [31:0] acc_data_s;
    logic [3:0]  acc_mask_s;
    logic [27:0] acc_word_s;
    logic        acc_empty_s, acc_full_s, acc_same_s;

    assign accept_s   = px_valid && px_ready_q;
    assign in_range_s = (px_y < 8'(FB_HEIGHT));
    assign drop_s     = accept_s && !in_range_s;
    assign px_byte_s  = FB_BASE_ADDR + 30'(fb_offset(px_x, px_y));

    fb_word_merge u_merge (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (acc_load_s),
        .merge_i     (acc_merge_s),
        .clear_i     (acc_clear_s),
        .px_word_i   (px_byte_s[29:2]),
        .px_lane_i   (px_x[1:0]),
        .px_rgb_i    (px_rgb),
        .acc_data_o  (acc_data_s),
        .acc_mask_o  (acc_mask_s),
        .acc_word_o  (acc_word_s),
        .empty_o     (acc_empty_s),
        .full_o      (acc_full_s),
        .same_word_o (acc_same_s)
    );

`ifdef FB_CLEAR_EN
    localparam logic [16:0] BURST_BYTES = 17'(CLR_BURST * 4);
    logic [7:0]  clr_rgb_q, clr_rgb_d;
    logic [5:0]  clr_beat_q, clr_beat_d;
    logic [15:0] clr_off_q, clr_off_d;

    // Clear bookkeeping: pending flag, latched colour, beat within burst, burst offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_pend_q <= 1'b0;
            clr_rgb_q  <= 8'h00;
            clr_beat_q <= 6'd0;
            clr_off_q  <= 16'h0000;
        end else begin
            clr_pend_q <= clr_pend_d;
            clr_rgb_q  <= clr_rgb_d;
            clr_beat_q <= clr_beat_d;
            clr_off_q  <= clr_off_d;
        end
    end
`else
    logic unused_clr_s;
    assign clr_pend_q   = 1'b0;
    assign clr_pend_d   = 1'b0;
    assign unused_clr_s = ^{clr_start, clr_rgb};
`endif

    // Next-state, accumulator control and MIG strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;
        out_word_d  = out_word_q;
        acc_load_s  = 1'b0;
        acc_merge_s = 1'b0;
        acc_clear_s = 1'b0;
        wr_en_s     = 1'b0;
        cmd_en_s    = 1'b0;
`ifdef FB_CLEAR_EN
        clr_rgb_d  = clr_rgb_q;
        clr_beat_d = clr_beat_q;
        clr_off_d  = clr_off_q;
        // Only the first clr_start of a clear counts; later ones while pending are ignored.
        if (clr_start && !clr_pend_q) begin
            clr_pend_d = 1'b1;
            clr_rgb_d  = clr_rgb;
        end else begin
            clr_pend_d = clr_pend_q;
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (accept_s && in_range_s) begin
                    acc_load_s = 1'b1;
                    cnt_d      = 8'd0;
                    state_d    = S_ACCUM;
`ifdef FB_CLEAR_EN
                end else if (clr_pend_q) begin
                    state_d = S_CLR_DATA;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (accept_s && in_range_s) begin
                    cnt_d = 8'd0;
                    if (acc_same_s) begin
                        acc_merge_s = 1'b1;
                    end else begin
                        out_data_d = acc_data_s;
                        out_mask_d = acc_mask_s;
                        out_word_d = acc_word_s;
                        acc_load_s = 1'b1;
                        state_d    = S_WR_DATA;
                    end
                end else if (acc_full_s || flush || clr_pend_q || (cnt_q == 8'(FLUSH_TIMEOUT))) begin
                    out_data_d  = acc_data_s;
                    out_mask_d  = acc_mask_s;
                    out_word_d  = acc_word_s;
                    acc_clear_s = 1'b1;
                    state_d     = S_WR_DATA;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WR_DATA: begin
                wr_en_s = !mem_wr_full;
                if (!mem_wr_full) begin
                    state_d = S_WR_CMD;
                end else begin
                    state_d = S_WR_DATA;
                end
            end
            S_WR_CMD: begin
                cmd_en_s = !mem_cmd_full;
                if (mem_cmd_full) begin
                    state_d = S_WR_CMD;
                end else if (!acc_empty_s) begin
                    state_d = S_ACCUM;
`ifdef FB_CLEAR_EN
                end else if (clr_pend_q) begin
                    state_d = S_CLR_DATA;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef FB_CLEAR_EN
            S_CLR_DATA: begin
                wr_en_s = !mem_wr_full;
                if (mem_wr_full) begin
                    state_d = S_CLR_DATA;
                end else if (clr_beat_q == 6'(CLR_BURST - 1)) begin
                    clr_beat_d = 6'd0;
                    state_d    = S_CLR_CMD;
                end else begin
                    clr_beat_d = clr_beat_q + 6'd1;
                end
            end
            S_CLR_CMD: begin
                cmd_en_s = !mem_cmd_full;
                if (mem_cmd_full) begin
                    state_d = S_CLR_CMD;
                end else if ((17'(clr_off_q) + BURST_BYTES) >= 17'(FB_BYTES)) begin
                    clr_off_d  = 16'h0000;
                    clr_pend_d = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    clr_off_d = clr_off_q + 16'(CLR_BURST * 4);
                    state_d   = S_CLR_DATA;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Main state, timeout counter, outgoing word and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            out_data_q   <= 32'h0000_0000;
            out_mask_q   <= 4'h0;
            out_word_q   <= 28'h0;
            px_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            px_dropped_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_mask_q   <= out_mask_d;
            out_word_q   <= out_word_d;
            px_ready_q   <= ((state_d == S_IDLE) || (state_d == S_ACCUM)) && !clr_pend_d;
            busy_q       <= (state_d != S_IDLE);
            px_dropped_q <= drop_s;
            err_q        <= err_q || mem_wr_underrun || mem_wr_error;
        end
    end

    assign px_ready      = px_ready_q;
    assign busy          = busy_q;
    assign px_dropped    = px_dropped_q;
    assign err           = err_q;
    assign mem_cmd_instr = MIG_INSTR_WRITE;
    assign mem_cmd_en    = cmd_en_s;
    assign mem_wr_en     = wr_en_s;

`ifdef FB_CLEAR_EN
    assign mem_wr_data       = (state_q == S_CLR_DATA) ? {4{clr_rgb_q}} : out_data_q;
    assign mem_wr_mask       = (state_q == S_CLR_DATA) ? 4'h0 : out_mask_q;
    assign mem_cmd_bl        = (state_q == S_CLR_CMD) ? 6'(CLR_BURST - 1) : 6'd0;
    assign mem_cmd_byte_addr = (state_q == S_CLR_CMD) ? (FB_BASE_ADDR + 30'(clr_off_q))
                                                      : {out_word_q, 2'b00};
`else
    assign mem_wr_data       = out_data_q;
    assign mem_wr_mask       = out_mask_q;
    assign mem_cmd_bl        = 6'd0;
    assign mem_cmd_byte_addr = {out_word_q, 2'b00};
`endif

    logic unused_status_s;
    assign unused_status_s = ^{mem_cmd_empty, mem_wr_empty, mem_wr_count, px_byte_s[1:0]};

endmodule

// File: tb/tb_framebuf_writer.sv
// Directed bench for framebuf_writer: expected MIG commands are queued by the stimulus thread
// and a negedge monitor pairs each mem_cmd_en with its captured write beats.
module tb_framebuf_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        px_valid = 1'b0, flush = 1'b0, clr_start = 1'b0;
    logic [7:0]  px_x = 8'd0, px_y = 8'd0, px_rgb = 8'd0, clr_rgb = 8'd0;
    logic        mem_cmd_full = 1'b0, mem_cmd_empty = 1'b1;
    logic        mem_wr_full = 1'b0, mem_wr_empty = 1'b1;
    logic [6:0]  mem_wr_count = 7'd0;
    logic        mem_wr_underrun = 1'b0, mem_wr_error = 1'b0;
    logic        px_ready, busy, px_dropped, err, mem_cmd_en, mem_wr_en;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_mask;

    typedef struct {
        logic [29:0] addr;
        logic [5:0]  bl;
        logic [31:0] data;
        logic [3:0]  mask;
    } exp_t;

    exp_t        exp_q[$];
    logic [35:0] beats_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_cmd = 0;

    framebuf_writer dut (
        .clk(clk), .rst_n(rst_n),
        .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
        .flush(flush), .clr_start(clr_start), .clr_rgb(clr_rgb),
        .busy(busy), .px_dropped(px_dropped), .err(err),
        .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr), .mem_cmd_bl(mem_cmd_bl),
        .mem_cmd_byte_addr(mem_cmd_byte_addr), .mem_cmd_full(mem_cmd_full), .mem_cmd_empty(mem_cmd_empty),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
        .mem_wr_full(mem_wr_full), .mem_wr_empty(mem_wr_empty), .mem_wr_count(mem_wr_count),
        .mem_wr_underrun(mem_wr_underrun), .mem_wr_error(mem_wr_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_exp(input logic [29:0] a, input logic [5:0] bl, input logic [31:0] d,
                            input logic [3:0] m);
        exp_t e;
        e.addr = a; e.bl = bl; e.data = d; e.mask = m;
        exp_q.push_back(e);
    endtask

    // Drives one pixel and returns #1 after the accepting edge.
    task automatic send_px(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c);
        bit done = 1'b0;
        px_valid = 1'b1; px_x = x; px_y = y; px_rgb = c;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (px_ready === 1'b1) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        px_valid = 1'b0;
        check("px_accept_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0) done = 1'b1;
        end
        check("idle_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    // Monitor: collect write beats, and on each command compare against the oldest expectation.
    always @(negedge clk) begin
        exp_t        e;
        logic [35:0] b;
        if (rst_n) begin
            if (mem_wr_en) beats_q.push_back({mem_wr_mask, mem_wr_data});
            if (mem_cmd_en) begin
                n_cmd++;
                check("cmd_instr", {29'd0, mem_cmd_instr}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", mem_cmd_byte_addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_addr", {2'b00, mem_cmd_byte_addr}, {2'b00, e.addr});
                    check("cmd_bl", {26'd0, mem_cmd_bl}, {26'd0, e.bl});
                    for (int i = 0; i <= int'(e.bl); i++) begin
                        if (beats_q.size() == 0) begin
                            check("missing_beat", 32'd0, 32'd1);
                        end else begin
                            b = beats_q.pop_front();
                            check("wr_data", b[31:0], e.data);
                            check("wr_mask", {28'd0, b[35:32]}, {28'd0, e.mask});
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cmd_before;
        int  viol;
        bit  seen;

        #23;
        check("rst_px_ready", {31'd0, px_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmd_en", {31'd0, mem_cmd_en}, 32'd0);
        check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("rst_wr_mask", {28'd0, mem_wr_mask}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        cycles(2);

        // Two pixels in one word, flushed by the idle timeout.
        push_exp(30'h4, 6'd0, 32'h0000_BBAA, 4'b1100);
        send_px(8'd4, 8'd0, 8'hAA);
        send_px(8'd5, 8'd0, 8'hBB);
        cmd_before = n_cmd;
        cycles(10);
        check("no_early_flush", n_cmd, cmd_before);
        wait_idle(60);
        check("timeout_cmd_count", n_cmd, cmd_before + 1);

        // A full word goes out without waiting for the timeout.
        push_exp(30'h208, 6'd0, 32'h0403_0201, 4'b0000);
        cmd_before = n_cmd;
        for (int i = 0; i < 4; i++) send_px(8'(8 + i), 8'd2, 8'(i + 1));
        cycles(4);
        check("full_word_fast", n_cmd, cmd_before + 1);
        wait_idle(20);

        // Different word forces the first out; second leaves via timeout.
        push_exp(30'h0, 6'd0, 32'h0000_0001, 4'b1110);
        push_exp(30'h4, 6'd0, 32'h0000_0002, 4'b1110);
        send_px(8'd0, 8'd0, 8'h01);
        send_px(8'd4, 8'd0, 8'h02);
        wait_idle(80);

        // Write-data FIFO full holds the WR_DATA state.
        push_exp(30'h10C, 6'd0, 32'h0000_0077, 4'b1110);
        mem_wr_full = 1'b1;
        send_px(8'd12, 8'd1, 8'h77);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_wr_en !== 1'b0 || px_ready !== 1'b0) viol++;
        end
        check("stall_holds", viol, 0);
        @(posedge clk);
        #1 mem_wr_full = 1'b0;
        wait_idle(20);

        // Out-of-range pixel is swallowed.
        cmd_before = n_cmd;
        send_px(8'd0, 8'd192, 8'h55);
        check("drop_pulse", {31'd0, px_dropped}, 32'd1);
        check("drop_not_busy", {31'd0, busy}, 32'd0);
        cycles(1);
        check("drop_pulse_end", {31'd0, px_dropped}, 32'd0);
        cycles(20);
        check("drop_no_traffic", n_cmd, cmd_before);

        // Sticky error flag.
        mem_wr_underrun = 1'b1;
        cycles(1);
        mem_wr_underrun = 1'b0;
        cycles(3);
        check("err_sticky", {31'd0, err}, 32'd1);

        // Reset while stuck in WR_CMD.
        mem_cmd_full = 1'b1;
        send_px(8'd1, 8'd1, 8'h33);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        cycles(4);
        check("wrcmd_busy", {31'd0, busy}, 32'd1);
        check("wrcmd_ready", {31'd0, px_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_px_ready", {31'd0, px_ready}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_cmd_en", {31'd0, mem_cmd_en}, 32'd0);
        check("mid_rst_wr_data", mem_wr_data, 32'd0);
        check("mid_rst_addr", {2'b00, mem_cmd_byte_addr}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        beats_q.delete();
        mem_cmd_full = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);

`ifdef FB_CLEAR_EN
        for (int i = 0; i < 768; i++) push_exp(30'(i * 64), 6'd15, 32'h1C1C_1C1C, 4'h0);
        clr_rgb = 8'h1C;
        clr_start = 1'b1;
        cycles(1);
        clr_start = 1'b0;
        clr_rgb = 8'h00;
        check("clr_ready_drop", {31'd0, px_ready}, 32'd0);
        wait_idle(20000);
        cycles(2);
        check("clr_ready_back", {31'd0, px_ready}, 32'd1);
`endif

        seen = (exp_q.size() == 0);
        check("all_cmds_seen", {31'd0, seen}, 32'd1);
        check("no_stray_beats", beats_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
